// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan controller: hex glyph table,
// blank pattern and digit index width.
package seg7_pkg;

  localparam int NUM_W = 3;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low a..g glyphs for 0..F; entry 0 sits in the low 7 bits.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/seg7_hex_enc.sv
// Combinational nibble to active-low seven-segment (a..g) encoder.
module seg7_hex_enc
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nib];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 8-digit common-anode scan controller with frame-aligned
// display update. Optional decimal points: define SEG7_SCAN_DP_EN.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int DIV_CNT    = 50000,
  parameter int NUM_DIGITS = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      disp_data,
  input  logic             disp_load,
  output logic             disp_ack,
  input  logic [7:0]       digit_en,
`ifdef SEG7_SCAN_DP_EN
  input  logic [7:0]       dp_mask,
`endif
  output logic [NUM_W-1:0] num,
  output logic [7:0]       seg,
  output logic             frame_done
);

  localparam int               PW       = $clog2(DIV_CNT);
  localparam logic [PW-1:0]    PS_LAST  = PW'(DIV_CNT - 1);
  localparam logic [NUM_W-1:0] NUM_LAST = NUM_W'(NUM_DIGITS - 1);

  logic [PW-1:0]    presc;
  logic             tick, wrap, pending;
  logic [31:0]      staging, live, live_nxt;
  logic [NUM_W-1:0] num_nxt;
  logic [3:0]       nib;
  logic [6:0]       hex;
  logic             dp_bit;
  logic [7:0]       seg_nxt;

  assign tick       = (presc == PS_LAST);
  assign wrap       = tick && (num == NUM_LAST);
  assign frame_done = wrap;
  assign disp_ack   = wrap && pending;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) presc <= '0;
    else        presc <= tick ? '0 : presc + PW'(1);
  end

  // seg is built from next-state num/live so both outputs move on one edge.
  always_comb begin
    num_nxt = num;
    if (tick) num_nxt = (num == NUM_LAST) ? '0 : num + NUM_W'(1);
    live_nxt = disp_ack ? staging : live;
  end

  assign nib = live_nxt[{num_nxt, 2'b00} +: 4];

  seg7_hex_enc u_enc (
    .nib (nib),
    .seg (hex)
  );

`ifdef SEG7_SCAN_DP_EN
  logic [7:0] dp_stage, dp_live, dp_live_nxt;

  assign dp_live_nxt = disp_ack ? dp_stage : dp_live;
  assign dp_bit      = ~dp_live_nxt[num_nxt];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_stage <= '0;
      dp_live  <= '0;
    end else begin
      dp_live <= dp_live_nxt;
      if (disp_load) dp_stage <= dp_mask;
    end
  end
`else
  assign dp_bit = 1'b1;
`endif

  assign seg_nxt = digit_en[num_nxt] ? {dp_bit, hex} : SEG_BLANK;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num <= '0;
      seg <= SEG_BLANK;
    end else begin
      num <= num_nxt;
      seg <= seg_nxt;
    end
  end

  // A load in the apply cycle re-arms pending, so it lands one frame later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      staging <= '0;
      live    <= '0;
      pending <= 1'b0;
    end else begin
      live    <= live_nxt;
      pending <= disp_load | (pending & ~wrap);
      if (disp_load) staging <= disp_data;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl (DIV_CNT=4, NUM_DIGITS=8); covers the
// dp path when SEG7_SCAN_DP_EN is defined.
module tb_seg7_scan_ctrl;

  localparam int DIV = 4;
  localparam int ND  = 8;
  localparam int FR  = DIV * ND;

  localparam logic [7:0] HEX [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] disp_data;
  logic        disp_load;
  logic        disp_ack;
  logic [7:0]  digit_en;
  logic [2:0]  num;
  logic [7:0]  seg;
  logic        frame_done;
`ifdef SEG7_SCAN_DP_EN
  logic [7:0]  dp_mask;
`endif

  seg7_scan_ctrl #(.DIV_CNT(DIV), .NUM_DIGITS(ND)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .disp_data  (disp_data),
    .disp_load  (disp_load),
    .disp_ack   (disp_ack),
    .digit_en   (digit_en),
`ifdef SEG7_SCAN_DP_EN
    .dp_mask    (dp_mask),
`endif
    .num        (num),
    .seg        (seg),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          ack_seen = 0;
  logic [31:0] exp_live = '0;
  logic [7:0]  exp_dp = '0;
  logic [39:0] pend_q [$];

  // Inputs as seen by the DUT at each active edge.
  logic [7:0]  en_edge;
  logic        ld_edge;
  logic [39:0] ld_val;
  always @(posedge clk) begin
    en_edge = digit_en;
    ld_edge = disp_load && rst_n;
`ifdef SEG7_SCAN_DP_EN
    ld_val  = {dp_mask, disp_data};
`else
    ld_val  = {8'h00, disp_data};
`endif
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock: update the scoreboard, then compare every output to the model.
  task automatic step();
    int         ph, e_num;
    logic       e_fd, e_ack, dpb;
    logic [7:0] e_seg;
    logic [39:0] v;
    @(posedge clk); #1;
    cyc++;
    if (ld_edge) begin
      if (pend_q.size() > 0) pend_q[0] = ld_val;
      else pend_q.push_back(ld_val);
    end
    ph    = cyc % FR;
    e_num = ph / DIV;
    e_fd  = (ph == FR - 1);
    e_ack = e_fd && (pend_q.size() > 0);
`ifdef SEG7_SCAN_DP_EN
    dpb = ~exp_dp[e_num];
`else
    dpb = 1'b1;
`endif
    e_seg = en_edge[e_num] ? {dpb, HEX[exp_live[e_num*4 +: 4]][6:0]} : 8'hFF;
    chk("num", 32'(num), 32'(e_num));
    chk("frame_done", 32'(frame_done), 32'(e_fd));
    chk("disp_ack", 32'(disp_ack), 32'(e_ack));
    chk("seg", 32'(seg), 32'(e_seg));
    if (disp_ack) ack_seen++;
    if (e_ack) begin
      v = pend_q.pop_front();
      exp_live = v[31:0];
      exp_dp   = v[39:32];
    end
  endtask

  task automatic advance_to(input int ph);
    int n = 0;
    while ((cyc % FR) != ph && n < 2 * FR) begin
      step();
      n++;
    end
    chk("advance_to", 32'(cyc % FR), 32'(ph));
  endtask

  task automatic load(input logic [31:0] d, input logic [7:0] dp);
    disp_data = d;
    disp_load = 1'b1;
`ifdef SEG7_SCAN_DP_EN
    dp_mask = dp;
`else
    if (dp != 8'h00) $display("note: dp ignored in this build");
`endif
    step();
    disp_load = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; disp_load = 1'b0; disp_data = '0; digit_en = 8'hFF;
`ifdef SEG7_SCAN_DP_EN
    dp_mask = '0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_num", 32'(num), 0);
    chk("rst_seg", 32'(seg), 32'hFF);
    chk("rst_ack", 32'(disp_ack), 0);
    chk("rst_fd", 32'(frame_done), 0);
    rst_n = 1'b1;

    // Free-running scan of two frames with blank (zero) live data.
    repeat (2 * FR) step();

    // Load mid-frame at digit 3; applied at the wrap.
    advance_to(12);
    ack_seen = 0;
    load(32'h76543210, 8'h00);
    advance_to(31);
    chk("ld_ack_at_wrap", 32'(ack_seen), 1);
    step();
    chk("ld_d0", 32'(seg), 32'hC0);
    advance_to(4);
    chk("ld_d1", 32'(seg), 32'hF9);
    advance_to(28);
    chk("ld_d7", 32'(seg), 32'hF8);

    // Back-to-back loads: only the newest is applied, one ack.
    advance_to(4);
    ack_seen = 0;
    load(32'h11111111, 8'h00);
    repeat (5) step();
    load(32'hFEDCBA98, 8'h00);
    advance_to(31);
    step();
    chk("b2b_d0", 32'(seg), 32'h80);
    advance_to(28);
    chk("b2b_d7", 32'(seg), 32'h8E);
    chk("b2b_acks", 32'(ack_seen), 1);

    // Load coincident with the boundary tick.
    advance_to(8);
    load(32'h12345678, 8'h00);
    ack_seen = 0;
    advance_to(31);
    load(32'hAAAA5555, 8'h00);
    chk("coin_first_ack", 32'(ack_seen), 1);
    chk("coin_old_d0", 32'(seg), 32'h80);
    advance_to(31);
    chk("coin_second_ack", 32'(ack_seen), 2);
    step();
    chk("coin_new_d0", 32'(seg), 32'h92);

    // Blanking of the low four digits and 1-cycle reaction to digit_en.
    digit_en = 8'hF0;
    advance_to(4);
    chk("blank_d1", 32'(seg), 32'hFF);
    advance_to(20);
    chk("blank_d5", 32'(seg), 32'h88);
    advance_to(8);
    chk("blank_d2", 32'(seg), 32'hFF);
    digit_en = 8'hFF;
    step();
    chk("en_on_d2", 32'(seg), 32'h92);
    digit_en = 8'h00;
    step();
    chk("en_off_d2", 32'(seg), 32'hFF);
    digit_en = 8'hFF;
    step();

`ifdef SEG7_SCAN_DP_EN
    load(32'h00000000, 8'h01);
    advance_to(31);
    step();
    chk("dp_d0", 32'(seg), 32'h40);
    advance_to(4);
    chk("dp_d1", 32'(seg), 32'hC0);
`endif

    // Reset in the middle of a slot, with a load still pending.
    advance_to(9);
    load(32'h33333333, 8'h00);
    advance_to(13);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_num", 32'(num), 0);
    chk("mid_rst_seg", 32'(seg), 32'hFF);
    chk("mid_rst_ack", 32'(disp_ack), 0);
    chk("mid_rst_fd", 32'(frame_done), 0);
    @(posedge clk); #1;
    cyc = 0;
    exp_live = '0;
    exp_dp = '0;
    pend_q.delete();
    ack_seen = 0;
    rst_n = 1'b1;
    repeat (FR + 8) step();
    chk("post_rst_no_ack", 32'(ack_seen), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
